// File: rtl/dds_voice_alloc_pkg.sv
// Shared constants and FSM state type for the DDS voice allocator.
// Waveform codes match the counter output mux select encoding.
package dds_pkg;

    localparam int NOTE_W = 7;
    localparam int WAVE_W = 3;

    localparam logic [WAVE_W-1:0] WAVE_SAW        = 3'd0;
    localparam logic [WAVE_W-1:0] WAVE_REVSAW     = 3'd1;
    localparam logic [WAVE_W-1:0] WAVE_TRIANGL    = 3'd2;
    localparam logic [WAVE_W-1:0] WAVE_MEANDER    = 3'd3;
    localparam logic [WAVE_W-1:0] WAVE_MEANDER025 = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2
    } alloc_state_e;

endpackage

// File: rtl/dds_voice_slot.sv
// One DDS voice: note/wave/gate registers plus a saturating age counter.
// Only gated voices age; a load restarts the age at zero.
module dds_voice_slot
    import dds_pkg::*;
#(
    parameter int NOTE_W = dds_pkg::NOTE_W,
    parameter int AGE_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              rel,
    input  logic              age_inc,
    input  logic              age_clr,
    input  logic [NOTE_W-1:0] load_note,
    input  logic [WAVE_W-1:0] load_wave,
    output logic [NOTE_W-1:0] note,
    output logic [WAVE_W-1:0] wave,
    output logic              gate,
    output logic [AGE_W-1:0]  age
);

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    always_ff @(posedge clk) begin
        if (reset) begin
            note <= '0;
            wave <= '0;
            gate <= 1'b0;
            age  <= '0;
        end else begin
            if (load) begin
                note <= load_note;
                wave <= load_wave;
                gate <= 1'b1;
            end else if (rel) begin
                gate <= 1'b0;
            end
            if (age_clr) begin
                age <= '0;
            end else if (age_inc && gate && (age != AGE_MAX)) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dds_voice_alloc.sv
// Polyphonic voice allocator: accepts note events (valid/ready) and scans the voices
// one per cycle before applying. Stealing is enabled by DDS_VOICE_ALLOC_STEAL_EN.
module dds_voice_alloc
    import dds_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = dds_pkg::NOTE_W,
    parameter int AGE_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [2:0]                   ev_wave,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*3-1:0]      voice_wave,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic                         steal_pulse,
    output logic                         drop_pulse
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    // Handshake: an event transfers on a clock edge where ev_valid && ev_ready.
    alloc_state_e state, state_nx;

    logic [IDX_W-1:0]            scan_idx;
    logic                        lat_on;
    logic [NOTE_W-1:0]           lat_note;
    logic [WAVE_W-1:0]           lat_wave;
    logic                        match_found, free_found;
    logic [IDX_W-1:0]            match_idx, free_idx, tgt_idx;
    logic                        accept, do_alloc, apply_drop;
    logic [NUM_VOICES-1:0]       load_v, rel_v, inc_v;
    logic [NOTE_W-1:0]           slot_note [NUM_VOICES];
    logic [NUM_VOICES-1:0]       slot_gate;
    logic [NUM_VOICES*AGE_W-1:0] ages_flat;
    logic [NOTE_W-1:0]           cur_note;
    logic                        cur_gate;

    assign ev_ready = (state == IDLE) && !reset;
    assign accept   = ev_valid && ev_ready;
    assign cur_note = slot_note[scan_idx];
    assign cur_gate = slot_gate[scan_idx];

`ifdef DDS_VOICE_ALLOC_STEAL_EN
    logic                 old_found, apply_steal;
    logic [IDX_W-1:0]     old_idx;
    logic [AGE_W-1:0]     old_age, cur_age;
    assign cur_age = ages_flat[scan_idx*AGE_W +: AGE_W];
`else
    logic unused_age;
    assign unused_age  = ^ages_flat;
    assign steal_pulse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_nx = APPLY;
            APPLY:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_idx    <= '0;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            lat_wave    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
`ifdef DDS_VOICE_ALLOC_STEAL_EN
            old_found   <= 1'b0;
            old_idx     <= '0;
            old_age     <= '0;
`endif
        end else if (state == IDLE) begin
            if (accept) begin
                scan_idx    <= '0;
                lat_on      <= ev_on;
                lat_note    <= ev_note;
                lat_wave    <= ev_wave;
                match_found <= 1'b0;
                free_found  <= 1'b0;
`ifdef DDS_VOICE_ALLOC_STEAL_EN
                old_found   <= 1'b0;
`endif
            end
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (cur_gate && (cur_note == lat_note) && !match_found) begin
                match_found <= 1'b1;
                match_idx   <= scan_idx;
            end
            if (!cur_gate && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
`ifdef DDS_VOICE_ALLOC_STEAL_EN
            // Strict greater-than keeps the lowest index on equal ages.
            if (cur_gate && (!old_found || (cur_age > old_age))) begin
                old_found <= 1'b1;
                old_idx   <= scan_idx;
                old_age   <= cur_age;
            end
`endif
        end
    end

    always_comb begin
        load_v     = '0;
        rel_v      = '0;
        inc_v      = '0;
        do_alloc   = 1'b0;
        apply_drop = 1'b0;
        tgt_idx    = '0;
`ifdef DDS_VOICE_ALLOC_STEAL_EN
        apply_steal = 1'b0;
`endif
        if (state == APPLY) begin
            if (lat_on) begin
                if (match_found) begin
                    do_alloc = 1'b1;
                    tgt_idx  = match_idx;
                end else if (free_found) begin
                    do_alloc = 1'b1;
                    tgt_idx  = free_idx;
                end else begin
`ifdef DDS_VOICE_ALLOC_STEAL_EN
                    do_alloc    = 1'b1;
                    tgt_idx     = old_idx;
                    apply_steal = 1'b1;
`else
                    apply_drop  = 1'b1;
`endif
                end
            end else if (match_found) begin
                rel_v[match_idx] = 1'b1;
            end else begin
                apply_drop = 1'b1;
            end
            if (do_alloc) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (IDX_W'(i) == tgt_idx) load_v[i] = 1'b1;
                    else                      inc_v[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_pulse  <= 1'b0;
`ifdef DDS_VOICE_ALLOC_STEAL_EN
            steal_pulse <= 1'b0;
`endif
        end else begin
            drop_pulse  <= apply_drop;
`ifdef DDS_VOICE_ALLOC_STEAL_EN
            steal_pulse <= apply_steal;
`endif
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        dds_voice_slot #(
            .NOTE_W (NOTE_W),
            .AGE_W  (AGE_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load_v[i]),
            .rel       (rel_v[i]),
            .age_inc   (inc_v[i]),
            .age_clr   (load_v[i]),
            .load_note (lat_note),
            .load_wave (lat_wave),
            .note      (slot_note[i]),
            .wave      (voice_wave[i*3 +: 3]),
            .gate      (slot_gate[i]),
            .age       (ages_flat[i*AGE_W +: AGE_W])
        );
        assign voice_note[i*NOTE_W +: NOTE_W] = slot_note[i];
    end

    assign voice_gate = slot_gate;

endmodule

// File: tb/tb_dds_voice_alloc.sv
// Self-checking bench for dds_voice_alloc: directed test-plan sequence then random events,
// compared against an array-based allocation model (honours DDS_VOICE_ALLOC_STEAL_EN).
module tb_dds_voice_alloc;

    localparam int N      = 4;
    localparam int NW     = 7;
    localparam int AW     = 4;
    localparam int AGEMAX = (1 << AW) - 1;
    localparam int EXP_W  = N*NW + N*3 + N + 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            ev_valid;
    logic            ev_ready;
    logic            ev_on;
    logic [NW-1:0]   ev_note;
    logic [2:0]      ev_wave;
    logic [N*NW-1:0] voice_note;
    logic [N*3-1:0]  voice_wave;
    logic [N-1:0]    voice_gate;
    logic            steal_pulse;
    logic            drop_pulse;

    dds_voice_alloc #(.NUM_VOICES(N), .NOTE_W(NW), .AGE_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_on       (ev_on),
        .ev_note     (ev_note),
        .ev_wave     (ev_wave),
        .voice_note  (voice_note),
        .voice_wave  (voice_wave),
        .voice_gate  (voice_gate),
        .steal_pulse (steal_pulse),
        .drop_pulse  (drop_pulse)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // reference model: plain arrays, allocation rules applied directly
    logic [NW-1:0] m_note [N];
    logic [2:0]    m_wave [N];
    logic          m_gate [N];
    int            m_age  [N];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_note[i] = '0; m_wave[i] = '0; m_gate[i] = 1'b0; m_age[i] = 0;
        end
    endfunction

    function automatic logic [EXP_W-1:0] model_pack(input logic st, input logic dr);
        logic [N*NW-1:0] notes;
        logic [N*3-1:0]  waves;
        logic [N-1:0]    gates;
        for (int i = 0; i < N; i++) begin
            notes[i*NW +: NW] = m_note[i];
            waves[i*3 +: 3]   = m_wave[i];
            gates[i]          = m_gate[i];
        end
        return {notes, waves, gates, st, dr};
    endfunction

    function automatic logic [EXP_W-1:0] model_event(input logic on, input logic [NW-1:0] note,
                                                     input logic [2:0] wave);
        int match = -1;
        int free  = -1;
        int tgt   = -1;
        logic st  = 1'b0;
        logic dr  = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (m_gate[i] && m_note[i] == note) match = i;
            if (!m_gate[i]) free = i;
        end
        if (on) begin
            if (match >= 0) tgt = match;
            else if (free >= 0) tgt = free;
            else begin
`ifdef DDS_VOICE_ALLOC_STEAL_EN
                int best = -1;
                for (int i = 0; i < N; i++)
                    if (best < 0 || m_age[i] > m_age[best]) best = i;
                tgt = best;
                st  = 1'b1;
`else
                dr = 1'b1;
`endif
            end
            if (tgt >= 0) begin
                for (int i = 0; i < N; i++)
                    if (i != tgt && m_gate[i] && m_age[i] < AGEMAX) m_age[i]++;
                m_note[tgt] = note; m_wave[tgt] = wave; m_gate[tgt] = 1'b1; m_age[tgt] = 0;
            end
        end else begin
            if (match >= 0) m_gate[match] = 1'b0;
            else dr = 1'b1;
        end
        return model_pack(st, dr);
    endfunction

    // driver: present one event, then check timing and the applied result
    task automatic send_event(input logic on, input logic [NW-1:0] note, input logic [2:0] wave);
        int waited = 0;
        logic [N-1:0] prev_gate;
        logic [EXP_W-1:0] e;
        while (!ev_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ev_ready) begin
            check("ready_timeout", {63'd0, ev_ready}, 64'd1);
            return;
        end
        ev_valid = 1'b1; ev_on = on; ev_note = note; ev_wave = wave;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        for (int i = 0; i < N; i++) prev_gate[i] = m_gate[i];
        exp_q.push_back(model_event(on, note, wave));
        repeat (N) @(posedge clk);
        @(negedge clk);
        check("ready_busy", {63'd0, ev_ready}, 64'd0);
        check("gate_early", {60'd0, voice_gate}, {60'd0, prev_gate});
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check("voice_note", 64'(voice_note), 64'(e[EXP_W-1 -: N*NW]));
        check("voice_wave", 64'(voice_wave), 64'(e[N*3+N+1 -: N*3]));
        check("voice_gate", 64'(voice_gate), 64'(e[N+1 -: N]));
        check("steal_pulse", {63'd0, steal_pulse}, {63'd0, e[1]});
        check("drop_pulse", {63'd0, drop_pulse}, {63'd0, e[0]});
        check("ready_back", {63'd0, ev_ready}, 64'd1);
        @(negedge clk);
        check("pulses_clear", {62'd0, steal_pulse, drop_pulse}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_note"}, 64'(voice_note), 64'd0);
        check({tag, "_wave"}, 64'(voice_wave), 64'd0);
        check({tag, "_gate"}, 64'(voice_gate), 64'd0);
        check({tag, "_pulse"}, {62'd0, steal_pulse, drop_pulse}, 64'd0);
    endtask

    logic [NW-1:0] pool [8];

    initial begin
        logic [NW-1:0] rn;
        logic          ron;
        logic [2:0]    rw;
        reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_wave = '0;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", {63'd0, ev_ready}, 64'd0);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {63'd0, ev_ready}, 64'd1);

        // fill
        send_event(1'b1, 7'd60, 3'd2);
        send_event(1'b1, 7'd64, 3'd2);
        send_event(1'b1, 7'd67, 3'd2);
        send_event(1'b1, 7'd72, 3'd2);
        check("fill_notes", 64'(voice_note), 64'({7'd72, 7'd67, 7'd64, 7'd60}));
        check("fill_gates", 64'(voice_gate), 64'd15);

        // steal or drop on a full bank
        send_event(1'b1, 7'd76, 3'd1);
`ifdef DDS_VOICE_ALLOC_STEAL_EN
        check("steal_v0", 64'(voice_note[0 +: NW]), 64'd76);
`else
        check("nosteal_v0", 64'(voice_note[0 +: NW]), 64'd60);
`endif

        // release and reuse
        send_event(1'b0, 7'd64, 3'd0);
        check("release_note", 64'(voice_note[NW +: NW]), 64'd64);
        check("release_gate", 64'(voice_gate[1]), 64'd0);
        send_event(1'b1, 7'd50, 3'd4);
        check("reuse_v1", 64'(voice_note[NW +: NW]), 64'd50);

        // retrigger held note, then release of an unheld note
        send_event(1'b1, 7'd67, 3'd3);
        check("retrig_wave", 64'(voice_wave[2*3 +: 3]), 64'd3);
        send_event(1'b0, 7'd99, 3'd0);

        // reset during scan
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd80; ev_wave = 3'd1;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_midreset", {63'd0, ev_ready}, 64'd0);
        check_reset_outputs("midscan");
        reset = 1'b0;
        model_reset();
        repeat (N + 2) @(negedge clk);
        check_reset_outputs("post_abort");
        check("ready_post_abort", {63'd0, ev_ready}, 64'd1);

        // random events over a small note pool so matches, steals and saturation occur
        pool[0] = 7'd0;  pool[1] = 7'd127; pool[2] = 7'd60; pool[3] = 7'd61;
        pool[4] = 7'd62; pool[5] = 7'd63;  pool[6] = 7'd64; pool[7] = 7'd65;
        for (int k = 0; k < 160; k++) begin
            rn  = pool[$urandom_range(0, 7)];
            ron = ($urandom_range(0, 9) < 6);
            rw  = 3'($urandom_range(0, 4));
            send_event(ron, rn, rw);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
